// File: rtl/fmem_pkg.sv
// Shared types and helpers for the filter-coefficient buffer.
package fmem_pkg;

    localparam int DEF_T = 11;
    localparam int DEF_M = 9;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_state_t;

    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned m);
        if (ptr >= (m - 32'd1)) begin
            return 32'd0;
        end else begin
            return ptr + 32'd1;
        end
    endfunction

endpackage

// File: rtl/fmem_coeff_buffer_if.sv
// Load port, control/status and stream port of the coefficient buffer.
interface fmem_coeff_buffer_if #(
    parameter int T = fmem_pkg::DEF_T,
    parameter int M = fmem_pkg::DEF_M
) ();
    localparam int AW = $clog2(M);

    logic          s_load_valid;
    logic          s_load_ready;
    logic [T-1:0]  s_load_data;
    logic          start;
    logic          start_err;
    logic          busy;
    logic          loaded;
    logic          m_valid;
    logic          m_ready;
    logic [T-1:0]  m_data;
    logic [AW-1:0] m_idx;
    logic          m_last;

    modport master (
        output s_load_valid, s_load_data, start, m_ready,
        input  s_load_ready, start_err, busy, loaded, m_valid, m_data, m_idx, m_last
    );

    modport slave (
        input  s_load_valid, s_load_data, start, m_ready,
        output s_load_ready, start_err, busy, loaded, m_valid, m_data, m_idx, m_last
    );
endinterface

// File: rtl/fmem_bank.sv
// M x T coefficient RAM: one write port, one registered read port.
module fmem_bank #(
    parameter  int T  = fmem_pkg::DEF_T,
    parameter  int M  = fmem_pkg::DEF_M,
    localparam int AW = $clog2(M)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [T-1:0]  i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [T-1:0]  o_rdata
);
    logic [T-1:0] r_mem [M];
    logic [T-1:0] r_rdata;

    // Storage array; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read register holds its value whenever no read is issued.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata <= {T{1'b0}};
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/fmem_coeff_buffer.sv
// Loadable coefficient memory streaming M words in index order to the MAC array.
// Define FMEM_DBUF_EN for a shadow bank that loads while the active bank streams.
module fmem_coeff_buffer
    import fmem_pkg::*;
#(
    parameter int T = DEF_T,
    parameter int M = DEF_M
) (
    input logic               clk,
    input logic               reset_n,
    fmem_coeff_buffer_if.slave bus
);
    localparam int            AW       = $clog2(M);
    localparam logic [AW-1:0] LAST_IDX = AW'(M - 1);

    fsm_state_t    r_state, w_state_nxt;
    logic          r_busy, r_loaded, r_m_valid, r_m_last, r_start_err;
    logic [AW-1:0] r_wr_ptr, r_m_idx;
    logic          w_m_valid_nxt, w_start_err_nxt, w_re, w_xfer;
    logic          w_load_ready, w_load_fire, w_loaded_eff;
    logic [AW-1:0] w_m_idx_nxt, w_rd_addr;
    logic [T-1:0]  w_rdata0;

    assign w_load_fire = bus.s_load_valid && w_load_ready;
    assign w_xfer      = r_m_valid && bus.m_ready;

`ifdef FMEM_DBUF_EN
    logic         r_sel, r_rd_sel, r_shadow_full;
    logic         w_swap, w_act_sel;
    logic [T-1:0] w_rdata1;

    // A swap needs a full shadow and an idle stream, so RUN always finishes on its bank.
    assign w_swap       = (r_state == IDLE) && r_shadow_full;
    assign w_act_sel    = w_swap ? ~r_sel : r_sel;
    assign w_load_ready = !r_shadow_full;
    assign w_loaded_eff = r_loaded || w_swap;

    fmem_bank #(.T(T), .M(M)) u_bank0 (
        .clk(clk), .reset_n(reset_n),
        .i_we(w_load_fire && r_sel), .i_waddr(r_wr_ptr), .i_wdata(bus.s_load_data),
        .i_re(w_re && !w_act_sel), .i_raddr(w_rd_addr), .o_rdata(w_rdata0)
    );

    fmem_bank #(.T(T), .M(M)) u_bank1 (
        .clk(clk), .reset_n(reset_n),
        .i_we(w_load_fire && !r_sel), .i_waddr(r_wr_ptr), .i_wdata(bus.s_load_data),
        .i_re(w_re && w_act_sel), .i_raddr(w_rd_addr), .o_rdata(w_rdata1)
    );

    // Bank select, shadow occupancy and which bank's read register feeds m_data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sel         <= 1'b0;
            r_rd_sel      <= 1'b0;
            r_shadow_full <= 1'b0;
        end else begin
            if (w_swap) begin
                r_sel         <= ~r_sel;
                r_shadow_full <= 1'b0;
            end else if (w_load_fire && (r_wr_ptr == LAST_IDX)) begin
                r_shadow_full <= 1'b1;
            end
            if (w_re) begin
                r_rd_sel <= w_act_sel;
            end
        end
    end

    assign bus.m_data = r_rd_sel ? w_rdata1 : w_rdata0;
`else
    assign w_load_ready = !r_busy;
    assign w_loaded_eff = r_loaded;

    fmem_bank #(.T(T), .M(M)) u_bank0 (
        .clk(clk), .reset_n(reset_n),
        .i_we(w_load_fire), .i_waddr(r_wr_ptr), .i_wdata(bus.s_load_data),
        .i_re(w_re), .i_raddr(w_rd_addr), .o_rdata(w_rdata0)
    );

    assign bus.m_data = w_rdata0;
`endif

    // Next-state logic; the read for word i+1 is issued in the cycle word i transfers.
    always_comb begin
        w_state_nxt     = r_state;
        w_m_valid_nxt   = r_m_valid;
        w_m_idx_nxt     = r_m_idx;
        w_start_err_nxt = 1'b0;
        w_re            = 1'b0;
        w_rd_addr       = {AW{1'b0}};
        case (r_state)
            IDLE: begin
                if (bus.start && w_loaded_eff) begin
                    w_state_nxt   = RUN;
                    w_m_valid_nxt = 1'b1;
                    w_m_idx_nxt   = {AW{1'b0}};
                    w_re          = 1'b1;
                end else if (bus.start) begin
                    w_start_err_nxt = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                w_start_err_nxt = bus.start;
                if (w_xfer && (r_m_idx == LAST_IDX)) begin
                    w_state_nxt   = IDLE;
                    w_m_valid_nxt = 1'b0;
                end else if (w_xfer) begin
                    w_m_idx_nxt = AW'(ptr_inc(32'(r_m_idx), M));
                    w_re        = 1'b1;
                    w_rd_addr   = w_m_idx_nxt;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt   = IDLE;
                w_m_valid_nxt = 1'b0;
            end
        endcase
    end

    // State and registered stream/status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_m_valid   <= 1'b0;
            r_m_idx     <= {AW{1'b0}};
            r_m_last    <= 1'b0;
            r_start_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_busy      <= (w_state_nxt == RUN);
            r_m_valid   <= w_m_valid_nxt;
            r_m_idx     <= w_m_idx_nxt;
            r_m_last    <= w_m_valid_nxt && (w_m_idx_nxt == LAST_IDX);
            r_start_err <= w_start_err_nxt;
        end
    end

    // Write pointer and filter-complete flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= {AW{1'b0}};
            r_loaded <= 1'b0;
        end else begin
            if (w_load_fire) begin
                r_wr_ptr <= AW'(ptr_inc(32'(r_wr_ptr), M));
            end
`ifdef FMEM_DBUF_EN
            if (w_swap) begin
                r_loaded <= 1'b1;
            end
`else
            if (w_load_fire && (r_wr_ptr == LAST_IDX)) begin
                r_loaded <= 1'b1;
            end
`endif
        end
    end

    assign bus.s_load_ready = w_load_ready;
    assign bus.start_err    = r_start_err;
    assign bus.busy         = r_busy;
    assign bus.loaded       = r_loaded;
    assign bus.m_valid      = r_m_valid;
    assign bus.m_idx        = r_m_idx;
    assign bus.m_last       = r_m_last;
endmodule

// File: doc/fmem_coeff_buffer.md
Name: fmem_coeff_buffer

Overview:
Writable, parametrised filter-coefficient memory for the 1-D CNN datapath. It loads M signed T-bit coefficients through a valid/ready load port. On a start pulse it streams them in index order (0..M-1) to the MAC array over a valid/ready port with back-pressure. An optional shadow bank lets a new filter be loaded while the current one streams.

Parameters:
T, 11, coefficient width in bits (two's complement)
M, 9, number of coefficients per filter (M >= 2)
AW, $clog2(M), index/pointer width (localparam, derived, not overridable)

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
s_load_valid  in  1  load word valid
s_load_ready  out  1  block can accept a load word
s_load_data  in  T  coefficient to write
start  in  1  single-cycle request to stream the active filter
start_err  out  1  one-cycle pulse: start rejected
busy  out  1  stream in progress (state RUN)
loaded  out  1  active bank holds a complete filter
m_valid  out  1  stream word valid
m_ready  in  1  downstream accepts word
m_data  out  T  coefficient at m_idx
m_idx  out  AW  index of m_data
m_last  out  1  m_valid && m_idx==M-1

Behaviour:
- Reset (async assert, sync release): state IDLE, wr_ptr=0, rd_ptr=0, loaded=0, m_valid=0, m_data=0, m_idx=0, busy=0, start_err=0. Memory contents are not reset. Reset mid-stream aborts the stream and drops m_valid immediately.
- Load: a write occurs when s_load_valid && s_load_ready. mem[wr_ptr] <= s_load_data, then wr_ptr++. At wr_ptr==M-1 it wraps to 0 and sets loaded=1.
- Further loads after wrap overwrite from index 0; loaded stays 1.
- Without FMEM_DBUF_EN: s_load_ready = !busy.
- FSM IDLE: start && loaded -> RUN. In the next cycle m_valid=1, m_data=mem[0], m_idx=0. One cycle start-to-first-valid.
- FSM IDLE: start && !loaded -> start_err pulse on the next cycle; state stays IDLE.
- start while RUN is ignored and also pulses start_err.
- FSM RUN: a transfer occurs when m_valid && m_ready.
  - If m_idx<M-1: m_idx++ and m_data <= next word on the following cycle. This gives one word per cycle at full throughput.
  - If m_idx==M-1: m_valid<=0, state IDLE, busy<=0.
  - m_valid, m_data and m_idx are held stable while !m_ready.
- busy=1 from the cycle after an accepted start through the cycle of the last transfer.
- m_data is registered with a synchronous memory read; there is no combinational path from memory to output.
- Simultaneous load and start in IDLE is permitted. A load to index k in the same cycle as start is visible to the stream only if k>0.

Optional Feature:
Macro FMEM_DBUF_EN.
- Defined: two banks, active and shadow. Loads always target the shadow bank, independent of busy.
- When shadow wr_ptr wraps, shadow_full=1 and s_load_ready=0 until a swap occurs.
- Swap: in any cycle with state IDLE && shadow_full, the active/shadow select toggles, loaded=1 and shadow_full=0.
- A start in the swap cycle is serviced from the new active bank.
- A swap never happens in RUN; the stream always completes on the bank it began with.
- Not defined: a single bank and the base behaviour above; no shadow_full logic.

Decomposition:
- fmem_pkg:
  - fsm_state_t enum {IDLE, RUN}
  - default T and M constants
  - a ptr_inc function that wraps at M-1
- Sub-module fmem_bank: M x T simple dual-port RAM, with one write port and one synchronous-read port. Instantiated once, or twice under FMEM_DBUF_EN.

Test Plan:
1. Reset, then load 21,-8,11,-21,1,-19,-30,15,20 back-to-back. Pulse start with m_ready=1. Required: first m_valid one cycle after start; m_data sequence as loaded over 9 consecutive cycles; m_last only with 20 at m_idx=8; busy deasserts after that transfer.
2. Back-pressure: same load, m_ready toggling 1,0,0,1,… Required: m_data and m_idx held while m_ready=0; exactly 9 transfers; no duplicates or skips.
3. Start before load complete (5 words loaded). Required: start_err pulse, m_valid stays 0. After 4 more words, loaded=1 and start succeeds.
4. Load attempt during RUN (no DBUF): s_load_ready=0 throughout busy; a word held valid is accepted on the cycle after the last transfer.
5. Deassert reset_n at m_idx=4 mid-stream. Required: m_valid=0, loaded=0 and busy=0 asynchronously; a new start is rejected (start_err) until a full reload.
6. FMEM_DBUF_EN: while streaming filter A, load filter B (all values +7). Required: A streams unchanged. The swap occurs in the first IDLE cycle after A ends. The next start streams nine 7s. A 10th load word is stalled until the swap.
